bus_rr_arbiter: RTL

//  Round-robin arbiter for the shared bus in the hybrid NoC/bus cluster. Sits beside the bus

---
 rtl/bus_rr_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/bus_rr_arbiter.sv
// rtl/bus_rr_arbiter.sv - Round-robin shared-bus arbiter with ack timeout and turnaround cycle
module bus_rr_arbiter #(
    parameter int NUMBER_PES  = 4,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUMBER_PES-1:0]         request,
    input  logic [NUMBER_PES-1:0]         ack,
    input  logic [NUMBER_PES-1:0]         using_bus,
    output logic [NUMBER_PES-1:0]         grant,
    output logic [$clog2(NUMBER_PES)-1:0] owner,
    output logic                          bus_busy,
    output logic                          timeout
);
    localparam int W = $clog2(NUMBER_PES);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_BUSY, S_RELEASE} state_t;

    state_t                state_q, state_d;
    logic [NUMBER_PES-1:0] grant_q, grant_d;
    logic [W-1:0]          owner_q, owner_d;
    logic [W-1:0]          last_q, last_d;
    logic [7:0]            timer_q, timer_d;
    logic                  bus_busy_q, bus_busy_d;
    logic                  timeout_q, timeout_d;
    logic                  seen_q, seen_d;
    logic [W-1:0]          winner, cand;
    logic                  own_req, own_ack, own_use;

    assign own_req = request[owner_q];
    assign own_ack = ack[owner_q];
    assign own_use = using_bus[owner_q];

    // Scan from the far end back toward last+1 so the nearest requester after last wins.
    always_comb begin
        winner = last_q;
        cand   = last_q;
        for (int i = NUMBER_PES; i >= 1; i--) begin
            cand = W'((int'(last_q) + i) % NUMBER_PES);
            if (request[cand]) winner = cand;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        last_d    = last_q;
        timer_d   = timer_q;
        seen_d    = seen_q;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|request) begin
                    state_d = S_GRANT;
                    grant_d = NUMBER_PES'(1) << winner;
                    owner_d = winner;
                    timer_d = 8'd0;
                    seen_d  = 1'b0;
                end
            end
            S_GRANT: begin
                if (own_ack) begin
                    state_d = S_BUSY;
                end else if (!own_req) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    last_d  = owner_q;
                end else if (timer_q == 8'(ACK_TIMEOUT - 1)) begin
                    state_d   = S_IDLE;
                    grant_d   = '0;
                    last_d    = owner_q;
                    timeout_d = 1'b1;
                end else if (timer_q != 8'hFF) begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_BUSY: begin
                // A master that acked but never drove using_bus releases by dropping ack.
                if (own_use) begin
                    seen_d = 1'b1;
                end else if (seen_q || !own_ack) begin
                    state_d = S_RELEASE;
                    grant_d = '0;
                    last_d  = owner_q;
                end
            end
            S_RELEASE: state_d = S_IDLE;
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
        bus_busy_d = (state_d == S_GRANT) || (state_d == S_BUSY);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            last_q     <= W'(NUMBER_PES - 1);
            timer_q    <= 8'd0;
            bus_busy_q <= 1'b0;
            timeout_q  <= 1'b0;
            seen_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            timer_q    <= timer_d;
            bus_busy_q <= bus_busy_d;
            timeout_q  <= timeout_d;
            seen_q     <= seen_d;
        end
    end

    assign grant    = grant_q;
    assign owner    = owner_q;
    assign bus_busy = bus_busy_q;
    assign timeout  = timeout_q;

endmodule
